mac_operand_aligner: RTL and testbench
======================================

MAC_OPERAND_ALIGNER -- requirements
Module: mac_operand_aligner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning operand width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning entries per operand FIFO (power of two).
REQ-003 The block SHALL have parameter FRAME_LEN, default 8, meaning operand pairs per MAC accumulation frame.
REQ-004 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, meaning the synchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1, meaning a synchronous clear of buffered operands and the frame counter.
REQ-007 The block SHALL have port a_data, input, DATA_W, meaning the A-stream operand.
REQ-008 The block SHALL have port a_valid, input, 1, meaning a_data is offered.
REQ-009 The block SHALL have port a_ready, output, 1, meaning the A FIFO can accept.
REQ-010 The block SHALL have port b_data, input, DATA_W, meaning the B-stream operand.
REQ-011 The block SHALL have port b_valid, input, 1, meaning b_data is offered.
REQ-012 The block SHALL have port b_ready, output, 1, meaning the B FIFO can accept.
REQ-013 The block SHALL have port in_a, output, DATA_W, meaning the aligned A operand to the MAC.
REQ-014 The block SHALL have port in_b, output, DATA_W, meaning the aligned B operand to the MAC.
REQ-015 The block SHALL have port in_valid_a, output, 1, meaning in_a is valid this cycle.
REQ-016 The block SHALL have port in_valid_b, output, 1, meaning in_b is valid this cycle.
REQ-017 The block SHALL have port pair_idx, output, clog2(FRAME_LEN), meaning the in-frame index of the pair currently presented.
REQ-018 The block SHALL have port frame_done, output, 1, meaning the presented pair is the last of its frame.

Function
REQ-019 The A and B streams SHALL each be buffered in an independent DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy count of 0..DEPTH.
REQ-020 a_ready SHALL equal (count_a < DEPTH) and b_ready SHALL equal (count_b < DEPTH), both registered-state-derived only with no pop-through, so a full FIFO never accepts a push even in a pop cycle.
REQ-021 A push SHALL occur on a clock edge where valid && ready; data enters the tail and the count increments unless a pop occurs on the same edge.
REQ-022 A pop SHALL occur on every edge where count_a > 0 and count_b > 0, removing both heads together; the two streams are never popped separately.
REQ-023 On a pop edge, in_a/in_b SHALL register the popped heads and in_valid_a = in_valid_b = 1 for exactly the following cycle; on a non-pop edge, both valids SHALL be 0 and in_a/in_b SHALL be 0.
REQ-024 in_valid_a and in_valid_b SHALL always be equal.
REQ-025 Latency: a pair pushed on edge N into empty FIFOs SHALL appear with valids high after edge N+1, so throughput is one pair per cycle when both streams are sustained.
REQ-026 Skew tolerance: one stream SHALL be able to lead the other by up to DEPTH operands without loss; beyond that the leading stream is back-pressured via ready.
REQ-027 Simultaneous push and pop on one FIFO SHALL leave its count unchanged and SHALL preserve order.
REQ-028 pair_idx SHALL count presented pairs 0..FRAME_LEN-1, wrapping to 0 after FRAME_LEN-1, and advance only on presented pairs.
REQ-029 frame_done SHALL be 1 exactly when a presented pair has pair_idx = FRAME_LEN-1.
REQ-030 flush SHALL, on its edge, empty both FIFOs, zero pair_idx, and zero the outputs; any push or pop on that edge SHALL be discarded.

Reset
REQ-031 While reset = 0 at a rising edge, the block SHALL clear both FIFO pointers and counts and set in_a = 0, in_b = 0, in_valid_a = 0, in_valid_b = 0, pair_idx = 0, and frame_done = 0.
REQ-032 After reset, a_ready and b_ready SHALL be 1.
REQ-033 Reset asserted mid-frame SHALL discard all buffered operands and restart framing at pair_idx 0.
REQ-034 Reset SHALL take priority over flush, push, and pop.
REQ-035 FIFO storage contents need not be reset.

Structure
REQ-036 The shared package SHALL hold DATA_W, DEPTH, and FRAME_LEN defaults and a pointer-width constant.
REQ-037 A single sub-module, op_fifo, SHALL implement one stream FIFO and be instantiated twice (A and B).
REQ-038 The pairing, output register, and frame counter SHALL live in the top module.

Verification
REQ-039 Push A = 3,5 and B = 2,7 simultaneously over two cycles, then idle -> pairs (3,2) and (5,7) presented on consecutive cycles at pair_idx 0 and 1, starting one cycle after the first push.
REQ-040 Push A = 1,2,3,4,5 with no B -> a_ready is 0 after 4 pushes and the 5th push is held; then push B = 9,9,9,9 -> pairs (1,9) through (4,9) are presented and the held 5 is then accepted.
REQ-041 Stream 16 matched pairs back-to-back -> valids high for 16 consecutive cycles and frame_done high on the 8th and 16th pairs.
REQ-042 Load 3 A and 1 B operands, then assert flush -> the next cycle has valids 0, pair_idx 0, and both ready signals 1, and no stale operand appears later.
REQ-043 Assert reset (0) after the 5th pair of a frame -> all outputs are 0, and the first post-reset pair is presented with pair_idx 0.
REQ-044 Drive an A = 15 and B = 15 stream of 8 pairs into the MAC -> the MAC's result is 1800, and out_valid is asserted once.

Source files
------------

// File: rtl/mac_operand_aligner_pkg.sv
// Shared defaults and sizing helpers for the MAC operand aligner.
package mac_operand_aligner_pkg;

  localparam int DEF_DATA_W    = 4;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_FRAME_LEN = 8;

  // Index width for n entries, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PTR_W = width_of(DEF_DEPTH);

endpackage

// File: rtl/mac_operand_aligner_op_fifo.sv
// One operand stream buffer: circular FIFO with wrapping pointers and an
// explicit 0..DEPTH occupancy count.
module op_fifo
  import mac_operand_aligner_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              not_empty
);

  localparam int PTR_W = width_of(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop_en;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready looks only at the stored count, so a full FIFO refuses a push even
  // while it is being popped on the same edge.
  assign push_ready = (count < CNT_W'(DEPTH));
  assign not_empty  = (count != '0);
  assign push       = push_valid && push_ready && !flush;
  assign pop_en     = pop && not_empty && !flush;
  assign head_data  = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wrap_inc(wr_ptr);
      if (pop_en) rd_ptr <= wrap_inc(rd_ptr);
      if (push && !pop_en)      count <= count + CNT_W'(1);
      else if (pop_en && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are meaningful, so clearing the data would only cost area.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mac_operand_aligner.sv
// Aligns two independently arriving operand streams into lock-step pairs for a
// MAC, tagging each pair with its position in the accumulation frame.
module mac_operand_aligner
  import mac_operand_aligner_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [DATA_W-1:0]              a_data,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [DATA_W-1:0]              b_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  output logic [DATA_W-1:0]              in_a,
  output logic [DATA_W-1:0]              in_b,
  output logic                           in_valid_a,
  output logic                           in_valid_b,
  output logic [width_of(FRAME_LEN)-1:0] pair_idx,
  output logic                           frame_done
);

  localparam int IDX_W = width_of(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic              has_a;
  logic              has_b;
  logic              pop;
  logic              pair_valid;
  logic [IDX_W-1:0]  frame_cnt;

  // Both heads leave together; a lone operand waits for its partner.
  assign pop = has_a && has_b && !flush;

  op_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_data  (a_data),
    .push_valid (a_valid),
    .push_ready (a_ready),
    .pop        (pop),
    .head_data  (head_a),
    .not_empty  (has_a)
  );

  op_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_data  (b_data),
    .push_valid (b_valid),
    .push_ready (b_ready),
    .pop        (pop),
    .head_data  (head_b),
    .not_empty  (has_b)
  );

  // A single valid flop drives both valid outputs so they can never diverge.
  assign in_valid_a = pair_valid;
  assign in_valid_b = pair_valid;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      in_a       <= '0;
      in_b       <= '0;
      pair_valid <= 1'b0;
      pair_idx   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (pop) begin
      in_a       <= head_a;
      in_b       <= head_b;
      pair_valid <= 1'b1;
      pair_idx   <= frame_cnt;
      frame_done <= (frame_cnt == LAST_IDX);
      frame_cnt  <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + IDX_W'(1);
    end else begin
      in_a       <= '0;
      in_b       <= '0;
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_operand_aligner.sv
// Self-checking bench: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based model.
module tb_mac_operand_aligner;
  import mac_operand_aligner_pkg::*;

  localparam int DW = 4;
  localparam int DP = 4;
  localparam int FL = 8;
  localparam int IW = 3;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_valid_a;
  logic          in_valid_b;
  logic [IW-1:0] pair_idx;
  logic          frame_done;

  mac_operand_aligner #(.DATA_W(DW), .DEPTH(DP), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid_a (in_valid_a),
    .in_valid_b (in_valid_b),
    .pair_idx   (pair_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: two bounded queues and a running pair number.
  int qa[$];
  int qb[$];
  int m_pairs;
  int m_valid, m_a, m_b, m_idx, m_done, m_idx_known;

  // Observation helpers filled as the bench steps.
  int seq_a[$];
  int mac_acc, mac_result, mac_outs;

  task automatic model_step(input int rs, input int fl, input int av, input int ad,
                            input int bv, input int bd);
    int do_pop, pa, pb;
    if (rs == 0 || fl != 0) begin
      qa.delete();
      qb.delete();
      m_pairs = 0;
      m_valid = 0; m_a = 0; m_b = 0; m_idx = 0; m_done = 0; m_idx_known = 1;
    end else begin
      do_pop = (qa.size() > 0 && qb.size() > 0) ? 1 : 0;
      pa = (av != 0 && qa.size() < DP) ? 1 : 0;
      pb = (bv != 0 && qb.size() < DP) ? 1 : 0;
      if (do_pop != 0) begin
        m_a = qa.pop_front();
        m_b = qb.pop_front();
        m_valid = 1;
        m_idx = m_pairs % FL;
        m_done = (m_idx == FL - 1) ? 1 : 0;
        m_pairs++;
        m_idx_known = 1;
      end else begin
        m_valid = 0; m_a = 0; m_b = 0; m_done = 0; m_idx_known = 0;
      end
      if (pa != 0) qa.push_back(ad);
      if (pb != 0) qb.push_back(bd);
    end
  endtask

  task automatic drive(input int rs, input int fl, input int av, input int ad,
                       input int bv, input int bd);
    reset   = (rs != 0);
    flush   = (fl != 0);
    a_valid = (av != 0);
    a_data  = DW'(ad);
    b_valid = (bv != 0);
    b_data  = DW'(bd);
    model_step(rs, fl, av, ad, bv, bd);
    @(posedge clk);
    #1;
    if (in_valid_a) begin
      seq_a.push_back(int'(in_a));
      mac_acc += int'(in_a) * int'(in_b);
      if (frame_done) begin
        mac_result = mac_acc;
        mac_outs++;
        mac_acc = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " in_valid_a"}, int'(in_valid_a), m_valid);
    check({tag, " in_valid_b"}, int'(in_valid_b), m_valid);
    check({tag, " in_a"}, int'(in_a), m_a);
    check({tag, " in_b"}, int'(in_b), m_b);
    check({tag, " frame_done"}, int'(frame_done), m_done);
    check({tag, " a_ready"}, int'(a_ready), (qa.size() < DP) ? 1 : 0);
    check({tag, " b_ready"}, int'(b_ready), (qb.size() < DP) ? 1 : 0);
    if (m_idx_known != 0) check({tag, " pair_idx"}, int'(pair_idx), m_idx);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int fl, av, ad, bv, bd;
    int ev, ea, eb, ei, ed, ear, ebr;
  } vec_t;

  vec_t vt[11];

  // REQ-040: A backs up four deep, the fifth A waits for room.
  task automatic seq_backpressure();
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1, 0, 1, i, 0, 0);
    check("bp a_ready after 4 pushes", int'(a_ready), 0);
    seq_a.delete();
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 1, 5, 1, 9);
      check_model("bp");
    end
    drive(1, 0, 0, 0, 1, 9);
    check_model("bp");
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 0, 0, 0, 0);
      check_model("bp");
    end
    drive(1, 0, 0, 0, 1, 9);
    drive(1, 0, 0, 0, 0, 0);
    check_model("bp last");
    check("bp pair count", seq_a.size(), 5);
    for (int i = 0; i < 5 && i < seq_a.size(); i++)
      check($sformatf("bp a order %0d", i), seq_a[i], i + 1);
  endtask

  // REQ-041: sixteen matched pairs back to back.
  task automatic seq_stream16();
    int vcount, first, run_ok, dones, done_ok;
    vcount = 0; first = -1; run_ok = 1; dones = 0; done_ok = 1;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1, 0, 1, c % 16, 1, (c * 3) % 16);
      else        drive(1, 0, 0, 0, 0, 0);
      check_model("s16");
      if (in_valid_a) begin
        if (first < 0) first = c;
        if (c != first + vcount) run_ok = 0;
        vcount++;
        if (frame_done) begin
          dones++;
          if (vcount != 8 && vcount != 16) done_ok = 0;
        end
      end
    end
    check("s16 valid cycles", vcount, 16);
    check("s16 consecutive", run_ok, 1);
    check("s16 first valid cycle", first, 1);
    check("s16 frame_done count", dones, 2);
    check("s16 frame_done position", done_ok, 1);
  endtask

  // REQ-042: flush with operands buffered; nothing stale may surface.
  task automatic seq_flush();
    int stale;
    stale = 0;
    do_reset();
    drive(1, 0, 1, 10, 1, 20);
    drive(1, 0, 1, 11, 0, 0);
    drive(1, 0, 1, 12, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("flush valid", int'(in_valid_a), 0);
    check("flush pair_idx", int'(pair_idx), 0);
    check("flush a_ready", int'(a_ready), 1);
    check("flush b_ready", int'(b_ready), 1);
    drive(1, 0, 0, 0, 1, 3);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, 0, 0);
      if (in_valid_a || in_valid_b) stale++;
    end
    check("flush no stale pair", stale, 0);
  endtask

  // REQ-043: reset in the middle of a frame.
  task automatic seq_mid_reset();
    int seen, c;
    seen = 0; c = 0;
    do_reset();
    while (seen < 5 && c < 20) begin
      drive(1, 0, 1, c % 16, 1, 1);
      if (in_valid_a) seen++;
      c++;
    end
    check("mr fifth pair reached", seen, 5);
    drive(0, 0, 1, 7, 1, 7);
    check("mr in_valid_a", int'(in_valid_a), 0);
    check("mr in_valid_b", int'(in_valid_b), 0);
    check("mr in_a", int'(in_a), 0);
    check("mr in_b", int'(in_b), 0);
    check("mr pair_idx", int'(pair_idx), 0);
    check("mr frame_done", int'(frame_done), 0);
    drive(1, 0, 1, 3, 1, 4);
    check("mr no leftover pair", int'(in_valid_a), 0);
    drive(1, 0, 0, 0, 0, 0);
    check("mr first pair valid", int'(in_valid_a), 1);
    check("mr first pair idx", int'(pair_idx), 0);
    check("mr first pair a", int'(in_a), 3);
    check("mr first pair b", int'(in_b), 4);
  endtask

  // REQ-044: a full frame of 15*15 products into a simple accumulator.
  task automatic seq_mac();
    do_reset();
    mac_acc = 0; mac_result = 0; mac_outs = 0;
    for (int c = 0; c < 8; c++) drive(1, 0, 1, 15, 1, 15);
    for (int c = 0; c < 3; c++) drive(1, 0, 0, 0, 0, 0);
    check("mac result", mac_result, 1800);
    check("mac out_valid count", mac_outs, 1);
  endtask

  task automatic seq_random();
    int rs, fl, pa_pct, pb_pct;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) begin
        pa_pct = 20 + int'($urandom_range(0, 80));
        pb_pct = 20 + int'($urandom_range(0, 80));
      end
      rs = ($urandom_range(0, 119) == 0) ? 0 : 1;
      fl = ($urandom_range(0, 59) == 0) ? 1 : 0;
      drive(rs, fl,
            (int'($urandom_range(0, 99)) < pa_pct) ? 1 : 0, int'($urandom_range(0, 15)),
            (int'($urandom_range(0, 99)) < pb_pct) ? 1 : 0, int'($urandom_range(0, 15)));
      check_model("rnd");
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;

    vt[0]  = '{fl:0, av:1, ad:3, bv:1, bd:2, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[1]  = '{fl:0, av:1, ad:5, bv:1, bd:7, ev:1, ea:3, eb:2, ei:0, ed:0, ear:1, ebr:1};
    vt[2]  = '{fl:0, av:0, ad:0, bv:0, bd:0, ev:1, ea:5, eb:7, ei:1, ed:0, ear:1, ebr:1};
    vt[3]  = '{fl:0, av:0, ad:0, bv:0, bd:0, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[4]  = '{fl:0, av:1, ad:6, bv:0, bd:0, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[5]  = '{fl:0, av:0, ad:0, bv:1, bd:1, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[6]  = '{fl:0, av:0, ad:0, bv:0, bd:0, ev:1, ea:6, eb:1, ei:2, ed:0, ear:1, ebr:1};
    vt[7]  = '{fl:1, av:1, ad:4, bv:1, bd:4, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[8]  = '{fl:0, av:0, ad:0, bv:0, bd:0, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[9]  = '{fl:0, av:1, ad:8, bv:1, bd:8, ev:0, ea:0, eb:0, ei:0, ed:0, ear:1, ebr:1};
    vt[10] = '{fl:0, av:0, ad:0, bv:0, bd:0, ev:1, ea:8, eb:8, ei:0, ed:0, ear:1, ebr:1};

    do_reset();
    check("reset in_valid_a", int'(in_valid_a), 0);
    check("reset in_valid_b", int'(in_valid_b), 0);
    check("reset in_a", int'(in_a), 0);
    check("reset in_b", int'(in_b), 0);
    check("reset pair_idx", int'(pair_idx), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset a_ready", int'(a_ready), 1);
    check("reset b_ready", int'(b_ready), 1);

    for (int i = 0; i < 11; i++) begin
      drive(1, vt[i].fl, vt[i].av, vt[i].ad, vt[i].bv, vt[i].bd);
      check($sformatf("vec%0d valid_a", i), int'(in_valid_a), vt[i].ev);
      check($sformatf("vec%0d valid_b", i), int'(in_valid_b), vt[i].ev);
      check($sformatf("vec%0d in_a", i), int'(in_a), vt[i].ea);
      check($sformatf("vec%0d in_b", i), int'(in_b), vt[i].eb);
      check($sformatf("vec%0d frame_done", i), int'(frame_done), vt[i].ed);
      check($sformatf("vec%0d a_ready", i), int'(a_ready), vt[i].ear);
      check($sformatf("vec%0d b_ready", i), int'(b_ready), vt[i].ebr);
      if (vt[i].ev != 0 || vt[i].fl != 0)
        check($sformatf("vec%0d pair_idx", i), int'(pair_idx), vt[i].ei);
    end

    seq_backpressure();
    seq_stream16();
    seq_flush();
    seq_mid_reset();
    seq_mac();
    seq_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
